ecc_52_enc_fault_detc_pipe: RTL

//  Write-side SECDED encoder for 52-bit FIFO/RAM words; it produces the codewords that ecc_52_fault_detc checks on read.
//  Two redundant ecc_52_cal instances (parity_out used, bypass tied 0) generate the 7-bit parity, and their results are compared.

---
 rtl/ecc_52_enc_fault_detc_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ecc_52_enc_fault_detc_pipe.sv
// SECDED (Hamming + overall parity) encoder for 52-bit memory words. Two redundant parity
// generators are cross-checked, and a one-shot injector can corrupt a chosen beat for decoder tests.

module ecc_52_cal #(
   parameter int DATA_WIDTH   = 52,
   parameter int PARITY_WIDTH = 7
) (
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    bypass,
   output logic [PARITY_WIDTH-1:0] parity_out
);

   logic [5:0] syn;
   logic [5:0] pos;

   // Data bits fill the non-power-of-two codeword positions 3,5,6,7,9,... in order, ending at 58.
   // The Hamming bits are the XOR of the positions of every set data bit.
   always_comb begin
      syn = '0;
      pos = 6'd3;
      for (logic [5:0] i = 6'd0; i < 6'd52; i++) begin
         if (data_in[i]) syn = syn ^ pos;
         pos = pos + 6'd1;
         if ((pos & (pos - 6'd1)) == 6'd0) pos = pos + 6'd1;
      end
   end

   // The overall parity bit covers the data and the Hamming bits, so any double error is detected.
   assign parity_out = bypass ? '0 : {^{data_in, syn}, syn};

endmodule

module ecc_52_enc_fault_detc_pipe #(
   parameter int DATA_WIDTH   = 52,
   parameter int PARITY_WIDTH = 7,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    bypass,
   input  logic                    ecc_fault_detc_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [PARITY_WIDTH-1:0] out_parity,
   output logic                    out_ecc_fault,
   output logic                    fault_sticky,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   input  logic                    fault_clr,
   input  logic                    inj_arm,
   input  logic                    inj_type,
   input  logic [5:0]              inj_pos0,
   input  logic [5:0]              inj_pos1,
   output logic                    inj_armed,
   output logic                    inj_done
);

   typedef enum logic {
      INJ_IDLE,
      INJ_ARMED
   } inj_state_t;

   localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH - 1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

   logic [PARITY_WIDTH-1:0] p0;
   logic [PARITY_WIDTH-1:0] p1;
   logic                    accept;
   logic                    beat_fault;
   logic [DATA_WIDTH-1:0]   inj_mask;

   inj_state_t inj_state;
   logic       inj_type_q;
   logic [5:0] inj_pos0_q;
   logic [5:0] inj_pos1_q;

   ecc_52_cal #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PARITY_WIDTH(PARITY_WIDTH)
   ) u_cal0 (
      .data_in   (in_data),
      .bypass    (1'b0),
      .parity_out(p0)
   );

   ecc_52_cal #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PARITY_WIDTH(PARITY_WIDTH)
   ) u_cal1 (
      .data_in   (in_data),
      .bypass    (1'b0),
      .parity_out(p1)
   );

   assign in_ready   = ~out_valid | out_ready;
   assign accept     = in_valid & in_ready;
   assign beat_fault = ecc_fault_detc_en & ~bypass & (p0 != p1);

   // Positions 52..63 shift the single set bit out of the word, so they flip nothing.
   always_comb begin
      inj_mask = '0;
      if (inj_state == INJ_ARMED) begin
         inj_mask = DATA_ONE << inj_pos0_q;
         if (inj_type_q) inj_mask = inj_mask ^ (DATA_ONE << inj_pos1_q);
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_parity    <= '0;
         out_ecc_fault <= 1'b0;
         fault_sticky  <= 1'b0;
         fault_cnt     <= '0;
      end else begin
         if (accept) begin
            out_valid     <= 1'b1;
            out_data      <= in_data ^ inj_mask;
            out_parity    <= bypass ? '0 : p0;
            out_ecc_fault <= beat_fault;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // A fault arriving with fault_clr restarts the count at one rather than zero.
         if (accept && beat_fault) begin
            fault_sticky <= 1'b1;
            if (fault_clr)                fault_cnt <= CNT_ONE;
            else if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + CNT_ONE;
         end else if (fault_clr) begin
            fault_sticky <= 1'b0;
            fault_cnt    <= '0;
         end
      end
   end

   // The arm is captured only from IDLE; the beat accepted in the arm cycle is left untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         inj_state  <= INJ_IDLE;
         inj_armed  <= 1'b0;
         inj_done   <= 1'b0;
         inj_type_q <= 1'b0;
         inj_pos0_q <= '0;
         inj_pos1_q <= '0;
      end else begin
         inj_done <= 1'b0;
         case (inj_state)
            INJ_IDLE: begin
               if (inj_arm) begin
                  inj_type_q <= inj_type;
                  inj_pos0_q <= inj_pos0;
                  inj_pos1_q <= inj_pos1;
                  inj_state  <= INJ_ARMED;
                  inj_armed  <= 1'b1;
               end
            end
            INJ_ARMED: begin
               if (accept) begin
                  inj_state <= INJ_IDLE;
                  inj_armed <= 1'b0;
                  inj_done  <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
